// File: rtl/restoring_div_ctrl.sv
// Unsigned restoring divider controller: one quotient bit per clock, using an external W+1-bit adder for trial subtraction.
// The adder interface must be exactly 7 bits wide (W=6). The adder operands are held at zero outside CALC.
module restoring_div_ctrl #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero,
  output logic [W:0]   add_a,
  output logic [W:0]   add_b,
  output logic         add_cin,
  input  logic [W:0]   add_sum,
  input  logic         add_cout
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [W-1:0]  rem;
  logic [W-1:0]  quo;
  logic [W-1:0]  divisor_reg;
  logic [CW-1:0] count;

  logic          in_calc;
  logic          last;
  logic [W:0]    shifted;
  logic [W-1:0]  rem_nxt;
  logic [W-1:0]  quo_nxt;
  // rem < divisor_reg always holds, so the adder's sum MSB carries no information.
  logic          unused_sum_msb;

  assign in_calc        = (state == S_CALC);
  assign busy           = in_calc;
  assign done           = (state == S_DONE);
  assign last           = (count == CW'(W - 1));
  assign unused_sum_msb = add_sum[W];

  always_comb begin
    shifted = {rem, quo[W-1]};
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    if (in_calc) begin
      add_a   = shifted;
      add_b   = ~{1'b0, divisor_reg};
      add_cin = 1'b1;
    end
    // Carry-out set means the trial subtraction did not borrow: keep the difference.
    rem_nxt = add_cout ? add_sum[W-1:0] : shifted[W-1:0];
    quo_nxt = {quo[W-2:0], add_cout};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      rem         <= '0;
      quo         <= '0;
      divisor_reg <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            quo         <= dividend;
            divisor_reg <= divisor;
            rem         <= '0;
            count       <= '0;
            if (divisor != '0) begin
              state <= S_CALC;
            end else begin
              state       <= S_DONE;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_CALC: begin
          rem   <= rem_nxt;
          quo   <= quo_nxt;
          count <= count + CW'(1);
          if (last) begin
            state       <= S_DONE;
            quotient    <= quo_nxt;
            remainder   <= rem_nxt;
            div_by_zero <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_div_ctrl.sv
// Directed and exhaustive bench for restoring_div_ctrl with a behavioural 7-bit adder in the loop.
module tb_restoring_div_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [5:0] dividend;
  logic [5:0] divisor;
  logic       busy;
  logic       done;
  logic [5:0] quotient;
  logic [5:0] remainder;
  logic       div_by_zero;
  logic [6:0] add_a;
  logic [6:0] add_b;
  logic       add_cin;
  logic [6:0] add_sum;
  logic       add_cout;

  int n_assert = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {7'd0, add_cin};

  restoring_div_ctrl #(.W(6)) dut (
    .clk(clk), .reset(reset), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Adder must only be exercised during CALC, and the sum MSB must be clear whenever subtraction succeeds.
  always @(negedge clk) begin
    if (mon_en) begin
      check("cin_only_calc", {31'd0, add_cin}, {31'd0, busy});
      if (!busy) begin
        check("add_a_idle", {25'd0, add_a}, 32'd0);
        check("add_b_idle", {25'd0, add_b}, 32'd0);
      end
      if (add_cout) check("sum_msb", {31'd0, add_sum[6]}, 32'd0);
    end
  end

  // Called at a negedge; returns at the negedge where done is high.
  task automatic do_div(input logic [5:0] a, input logic [5:0] b,
                        input logic [5:0] exp_q, input logic [5:0] exp_r, input string tag);
    int cyc;
    int nbusy;
    start = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; nbusy = 0;
    while (!done && cyc < 20) begin
      if (busy) nbusy++;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"},  cyc,   (b == 0) ? 32'd1 : 32'd7);
    check({tag, "_busy"}, nbusy, (b == 0) ? 32'd0 : 32'd6);
    check({tag, "_q"},    {26'd0, quotient},  {26'd0, exp_q});
    check({tag, "_r"},    {26'd0, remainder}, {26'd0, exp_r});
    check({tag, "_dbz"},  {31'd0, div_by_zero}, (b == 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    int ndone;
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_q",    {26'd0, quotient}, 32'd0);
    check("rst_r",    {26'd0, remainder}, 32'd0);
    check("rst_dbz",  {31'd0, div_by_zero}, 32'd0);
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    do_div(6'd45, 6'd7,  6'd6,  6'd3, "d45_7");
    @(negedge clk);
    check("done_1cyc", {31'd0, done}, 32'd0);
    check("hold_q",    {26'd0, quotient}, 32'd6);
    do_div(6'd63, 6'd1,  6'd63, 6'd0, "d63_1");
    do_div(6'd5,  6'd9,  6'd0,  6'd5, "d5_9");
    do_div(6'd63, 6'd63, 6'd1,  6'd0, "d63_63");
    @(negedge clk);
    do_div(6'd17, 6'd0,  6'd63, 6'd17, "d17_0");
    @(negedge clk);
    do_div(6'd45, 6'd7,  6'd6,  6'd3, "d45_7_after0");

    // Start while busy is ignored; a start in the done cycle is accepted.
    @(negedge clk);
    start = 1'b1; dividend = 6'd45; divisor = 6'd7;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    start = 1'b1; dividend = 6'd10; divisor = 6'd3;
    @(negedge clk); start = 1'b0;
    begin
      int cyc;
      cyc = 0;
      while (!done && cyc < 20) begin @(negedge clk); cyc++; end
      check("ign_lat", cyc, 32'd4);
    end
    check("ign_q", {26'd0, quotient},  32'd6);
    check("ign_r", {26'd0, remainder}, 32'd3);
    do_div(6'd10, 6'd3, 6'd3, 6'd1, "b2b_10_3");

    // Reset mid-CALC discards the division.
    @(negedge clk);
    start = 1'b1; dividend = 6'd45; divisor = 6'd7;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    mon_en = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_done", {31'd0, done}, 32'd0);
    check("mrst_q",    {26'd0, quotient}, 32'd0);
    check("mrst_r",    {26'd0, remainder}, 32'd0);
    check("mrst_dbz",  {31'd0, div_by_zero}, 32'd0);
    ndone = 0;
    repeat (10) begin @(negedge clk); if (done) ndone++; end
    check("mrst_nodone", ndone, 32'd0);
    do_div(6'd20, 6'd6, 6'd3, 6'd2, "d20_6");

    // Exhaustive sweep against the arithmetic reference.
    for (int a = 0; a < 64; a++) begin
      for (int b = 1; b < 64; b++) begin
        do_div(6'(a), 6'(b), 6'(a / b), 6'(a % b), "sweep");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
